iq_mag_sq: RTL



---
 rtl/iq_mag_pkg.sv | 22 ++
 rtl/iq_mag_sq_if.sv | 33 +++
 rtl/iq_abs.sv | 19 +
 rtl/iq_mag_sq.sv | 149 ++++++++++++++
 4 files changed

// File: rtl/iq_mag_pkg.sv
// ---------------------------------------------------------------------------
// iq_mag_pkg
// Shared definitions for the I/Q magnitude-squared block:
//   W      default signed sample width
//   XW     result width (2*W)
//   CNT_W  width of the multiplier bit counter
//   state_t  FSM states of the serial squarer
// ---------------------------------------------------------------------------
package iq_mag_pkg;

    localparam int W     = 16;
    localparam int XW    = 2 * W;
    localparam int CNT_W = $clog2(W);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SQ_I = 2'd1,
        SQ_Q = 2'd2,
        DONE = 2'd3
    } state_t;

endpackage

// File: rtl/iq_mag_sq_if.sv
// ---------------------------------------------------------------------------
// iq_mag_sq_if
// Handshake bundle for iq_mag_sq.
//   in_valid / in_ready   input sample handshake
//   i_in / q_in           signed two's-complement I and Q samples (W bits)
//   out_valid / out_ready result handshake
//   x                     unsigned I*I + Q*Q (2*W bits)
// Modports:
//   slave  - the squarer block
//   master - the producer/consumer driving it
// ---------------------------------------------------------------------------
interface iq_mag_sq_if #(
    parameter int W = iq_mag_pkg::W
);
    logic             in_valid;
    logic             in_ready;
    logic [W-1:0]     i_in;
    logic [W-1:0]     q_in;
    logic             out_valid;
    logic             out_ready;
    logic [2*W-1:0]   x;

    modport slave (
        input  in_valid, i_in, q_in, out_ready,
        output in_ready, out_valid, x
    );

    modport master (
        output in_valid, i_in, q_in, out_ready,
        input  in_ready, out_valid, x
    );

endinterface

// File: rtl/iq_abs.sv
// ---------------------------------------------------------------------------
// iq_abs
// Combinational signed-to-unsigned magnitude.
//   v_i   : W-bit signed two's-complement value
//   mag_o : W-bit unsigned |v_i|
// The most negative input -2^(W-1) negates to the bit pattern 2^(W-1),
// which is exactly its magnitude when read as unsigned, so no saturation
// is needed.
// ---------------------------------------------------------------------------
module iq_abs #(
    parameter int W = iq_mag_pkg::W
) (
    input  logic [W-1:0] v_i,
    output logic [W-1:0] mag_o
);

    assign mag_o = v_i[W-1] ? (~v_i + W'(1)) : v_i;

endmodule

// File: rtl/iq_mag_sq.sv
// ---------------------------------------------------------------------------
// iq_mag_sq
// Bit-serial I*I + Q*Q. A sample is accepted in IDLE, both magnitudes are
// latched, then |I| is squared over W cycles and |Q| over another W cycles
// with a shift-add multiplier (one multiplier bit per cycle) into a shared
// 2*W-bit accumulator. The result is held in DONE until taken.
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous, active-high reset
//   bus    iq_mag_sq_if slave (input sample handshake, result handshake)
// ---------------------------------------------------------------------------
module iq_mag_sq #(
    parameter int W = iq_mag_pkg::W
) (
    input  logic         clk,
    input  logic         reset,
    iq_mag_sq_if.slave   bus
);

    import iq_mag_pkg::*;

    localparam int RW = 2 * W;
    localparam int NW = (W > 1) ? $clog2(W) : 1;
    localparam logic [NW-1:0] LAST_BIT = NW'(W - 1);

    // -----------------------------------------------------------------------
    // Input magnitudes: lane 0 is I, lane 1 is Q
    // -----------------------------------------------------------------------
    logic [W-1:0] raw [2];
    logic [W-1:0] mag [2];

    assign raw[0] = bus.i_in;
    assign raw[1] = bus.q_in;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_abs
            iq_abs #(.W(W)) u_abs (
                .v_i   (raw[gi]),
                .mag_o (mag[gi])
            );
        end
    endgenerate

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    state_t          state_q, state_d;
    logic [W-1:0]    mag_i_q, mag_i_d;
    logic [W-1:0]    mag_q_q, mag_q_d;
    logic [RW-1:0]   acc_q,   acc_d;
    logic [NW-1:0]   cnt_q,   cnt_d;
    logic [RW-1:0]   x_q,     x_d;

    // Shift-add step shared by both squaring phases
    logic [W-1:0]    opnd;
    logic [RW-1:0]   partial;
    logic [RW-1:0]   acc_sum;

    always_comb begin
        opnd    = (state_q == SQ_I) ? mag_i_q : mag_q_q;
        partial = opnd[cnt_q] ? (RW'(opnd) << cnt_q) : '0;
        // Sum of two squares peaks at 2^(RW-1), so this never wraps
        acc_sum = acc_q + partial;
    end

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        mag_i_d = mag_i_q;
        mag_q_d = mag_q_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        x_d     = x_q;

        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    mag_i_d = mag[0];
                    mag_q_d = mag[1];
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = SQ_I;
                end
            end

            SQ_I: begin
                acc_d = acc_sum;
                if (cnt_q == LAST_BIT) begin
                    cnt_d   = '0;
                    state_d = SQ_Q;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            SQ_Q: begin
                acc_d = acc_sum;
                if (cnt_q == LAST_BIT) begin
                    cnt_d   = '0;
                    x_d     = acc_sum;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            mag_i_q <= '0;
            mag_q_q <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            x_q     <= '0;
        end else begin
            state_q <= state_d;
            mag_i_q <= mag_i_d;
            mag_q_q <= mag_q_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            x_q     <= x_d;
        end
    end

    // Handshake outputs decode straight from state so reset clears them
    // without waiting for a clock edge.
    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = (state_q == DONE);
    assign bus.x         = x_q;

endmodule
